ofifo_col: RTL and testbench

Column-aligned output FIFO between the PE array and the SFU. Each of the `col` array columns pushes psum words independently, with skewed timing. The block re-aligns them into full rows and presents each row to the SFU as `ofifo_out`/`ofifo_valid`, popped by `ofifo_rd`. Per-lane circular buffers give first-word-fall-through output, so the SFU can drive `ofifo_rd = ofifo_valid` directly.

---
 rtl/ofifo_col.sv | 88 ++++++++
 tb/tb_ofifo_col.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ofifo_col.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | ofifo_col : column-aligned output FIFO, per-lane pushes, whole-row pops
// | rev 1.0
// +----------------------------------------------------------------------------
module ofifo_col #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [col-1:0]             wr,
  input  logic [col*psum_bw-1:0]     in,
  input  logic                       ofifo_rd,
  output logic [col*psum_bw-1:0]     ofifo_out,
  output logic                       ofifo_valid,
  output logic                       o_full,
  output logic                       o_ready,
  output logic                       o_overflow,
  output logic [$clog2(depth):0]     o_count
);

  localparam int          AW    = $clog2(depth);
  localparam logic [AW:0] c_one = (AW+1)'(1);

  logic [col-1:0] full;
  logic [AW:0]    occ [col];
  logic [AW:0]    min_occ;
  logic [AW:0]    rp_q, rp_d;
  logic           overflow_q, overflow_d;
  logic           pop;

  always_comb begin
    min_occ = occ[0];
    for (int i = 1; i < col; i++) begin
      if (occ[i] < min_occ) min_occ = occ[i];
    end
  end

  // Lanes only ever pop together, so a single read pointer serves all of them.
  assign ofifo_valid = (min_occ != '0);
  assign pop         = ofifo_rd && ofifo_valid;
  assign rp_d        = pop ? rp_q + c_one : rp_q;
  assign overflow_d  = overflow_q | (|(wr & full));

  assign o_count    = min_occ;
  assign o_full     = |full;
  assign o_ready    = ~o_full;
  assign o_overflow = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      rp_q       <= rp_d;
      overflow_q <= overflow_d;
    end
  end

  generate
    for (genvar i = 0; i < col; i++) begin : g_lane
      logic [AW:0]        wp_q, wp_d;
      logic [psum_bw-1:0] mem_q [depth];
      logic               push;

      assign full[i]  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
      assign occ[i]   = wp_q - rp_q;
      // Fullness is judged on pre-edge state: a same-cycle pop does not rescue the push.
      assign push     = wr[i] && !full[i];
      assign wp_d     = push ? wp_q + c_one : wp_q;
      assign ofifo_out[i*psum_bw +: psum_bw] = mem_q[rp_q[AW-1:0]];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wp_q <= '0;
          for (int k = 0; k < depth; k++) mem_q[k] <= '0;
        end else begin
          wp_q <= wp_d;
          if (push) mem_q[wp_q[AW-1:0]] <= in[i*psum_bw +: psum_bw];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ofifo_col.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_ofifo_col : directed self-checking bench for ofifo_col
// | rev 1.0
// +----------------------------------------------------------------------------
module tb_ofifo_col;

  logic         clk;
  logic         reset;
  logic [7:0]   wr;
  logic [127:0] in;
  logic         ofifo_rd;
  logic [127:0] ofifo_out;
  logic         ofifo_valid;
  logic         o_full;
  logic         o_ready;
  logic         o_overflow;
  logic [6:0]   o_count;

  int n_chk = 0;
  int n_err = 0;

  ofifo_col #(.col(8), .psum_bw(16), .depth(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .in         (in),
    .ofifo_rd   (ofifo_rd),
    .ofifo_out  (ofifo_out),
    .ofifo_valid(ofifo_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow),
    .o_count    (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] row_all(input logic [15:0] v);
    return {8{v}};
  endfunction

  function automatic logic [127:0] row_fill(input int r);
    logic [127:0] x;
    for (int l = 0; l < 8; l++) x[l*16 +: 16] = {8'(l), 8'(r)};
    return x;
  endfunction

  logic [127:0] exp_row;

  initial begin
    reset = 1'b0; wr = '0; in = '0; ofifo_rd = 1'b0;

    // Reset held: activity on wr/ofifo_rd must not disturb anything
    wr = 8'hFF; in = {4{32'hA5A5_5A5A}}; ofifo_rd = 1'b1;
    repeat (3) tick();
    chk("rst_valid",    128'(ofifo_valid), 128'd0);
    chk("rst_full",     128'(o_full),      128'd0);
    chk("rst_ready",    128'(o_ready),     128'd1);
    chk("rst_overflow", 128'(o_overflow),  128'd0);
    chk("rst_count",    128'(o_count),     128'd0);
    chk("rst_out",      ofifo_out,         128'd0);
    wr = '0; ofifo_rd = 1'b0; in = '0;
    reset = 1'b1;

    // Skewed arrival: lane i pushes 0x0100+i on cycle i
    for (int i = 0; i < 8; i++) begin
      wr = 8'(1 << i);
      in = '0;
      in[i*16 +: 16] = 16'h0100 + 16'(i);
      tick();
      chk($sformatf("skew_valid_%0d", i), 128'(ofifo_valid), (i == 7) ? 128'd1 : 128'd0);
    end
    wr = '0;
    for (int l = 0; l < 8; l++) exp_row[l*16 +: 16] = 16'h0100 + 16'(l);
    chk("skew_out",   ofifo_out,        exp_row);
    chk("skew_count", 128'(o_count),    128'd1);
    ofifo_rd = 1'b1; tick(); ofifo_rd = 1'b0;
    chk("skew_pop_valid", 128'(ofifo_valid), 128'd0);
    chk("skew_pop_count", 128'(o_count),     128'd0);

    // Fill all 64 rows, then a dropped push on lane 3
    wr = 8'hFF;
    for (int r = 0; r < 64; r++) begin
      in = row_fill(r);
      tick();
    end
    wr = '0;
    chk("fill_full",  128'(o_full),     128'd1);
    chk("fill_ready", 128'(o_ready),    128'd0);
    chk("fill_count", 128'(o_count),    128'd64);
    chk("fill_ovf0",  128'(o_overflow), 128'd0);
    wr = 8'h08; in = '0; in[3*16 +: 16] = 16'hDEAD;
    tick();
    wr = '0;
    chk("ovf_set",   128'(o_overflow), 128'd1);
    chk("ovf_count", 128'(o_count),    128'd64);
    ofifo_rd = 1'b1;
    for (int r = 0; r < 64; r++) begin
      chk($sformatf("drain_%0d", r), ofifo_out, row_fill(r));
      tick();
      if (r == 0) chk("drain_unfull", 128'(o_full), 128'd0);
    end
    ofifo_rd = 1'b0;
    chk("drain_valid",  128'(ofifo_valid), 128'd0);
    chk("drain_sticky", 128'(o_overflow),  128'd1);

    // Streaming across pointer wrap: push every cycle, pop from the second on
    wr = 8'hFF; in = row_all(16'd0); ofifo_rd = 1'b0;
    tick();
    ofifo_rd = 1'b1;
    for (int k = 1; k < 200; k++) begin
      chk($sformatf("wrap_out_%0d", k - 1), ofifo_out, row_all(16'(k - 1)));
      chk($sformatf("wrap_cnt_%0d", k - 1), 128'(o_count), 128'd1);
      in = row_all(16'(k));
      tick();
    end
    wr = '0;
    chk("wrap_out_199", ofifo_out, row_all(16'd199));
    tick();
    ofifo_rd = 1'b0;
    chk("wrap_empty", 128'(ofifo_valid), 128'd0);

    // Invalid pop on a partial row, then completion with ofifo_rd still high
    wr = 8'h7F;
    for (int l = 0; l < 8; l++) in[l*16 +: 16] = 16'h0A00 + 16'(l);
    tick();
    wr = '0; ofifo_rd = 1'b1;
    tick();
    chk("inv_valid", 128'(ofifo_valid), 128'd0);
    chk("inv_count", 128'(o_count),     128'd0);
    wr = 8'h80;
    tick();
    wr = '0; ofifo_rd = 1'b0;
    for (int l = 0; l < 8; l++) exp_row[l*16 +: 16] = 16'h0A00 + 16'(l);
    chk("inv_valid2", 128'(ofifo_valid), 128'd1);
    chk("inv_out",    ofifo_out,         exp_row);
    chk("inv_count2", 128'(o_count),     128'd1);
    ofifo_rd = 1'b1; tick(); ofifo_rd = 1'b0;
    chk("inv_drained", 128'(ofifo_valid), 128'd0);

    // Asynchronous reset with 10 rows queued
    wr = 8'hFF;
    for (int r = 0; r < 10; r++) begin
      in = row_all(16'h5000 + 16'(r));
      tick();
    end
    wr = '0;
    chk("mid_count", 128'(o_count), 128'd10);
    reset = 1'b0;
    #2;
    chk("mid_rst_valid", 128'(ofifo_valid), 128'd0);
    chk("mid_rst_count", 128'(o_count),     128'd0);
    chk("mid_rst_out",   ofifo_out,         128'd0);
    chk("mid_rst_ovf",   128'(o_overflow),  128'd0);
    chk("mid_rst_ready", 128'(o_ready),     128'd1);
    #1;
    reset = 1'b1;
    wr = 8'hFF; in = row_all(16'h7777);
    tick();
    wr = '0;
    chk("post_count", 128'(o_count), 128'd1);
    chk("post_out",   ofifo_out,     row_all(16'h7777));
    ofifo_rd = 1'b1; tick(); ofifo_rd = 1'b0;
    chk("post_empty", 128'(ofifo_valid), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
